// File: rtl/oflow_MEM_buffer_define.sv
// Shared widths, capacity limit, FSM state type and depth-clamp helper for the
// oflow frame buffer control logic.
package oflow_MEM_buffer_define;

    localparam int unsigned TOTAL_FRAME_NUM_WIDTH       = 8;
    localparam int unsigned NUM_OF_HISTORY_FRAMES_WIDTH = 3;
    localparam int unsigned BBOX_NUM_WIDTH              = 6;
    localparam int unsigned ADDR_WIDTH                  = 6;
    localparam int unsigned NUM_SLOTS                   = 5;
    localparam int unsigned SLOT_WIDTH                  = 3;
    localparam int unsigned MAX_BBOX_PER_SLOT           = 32;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StClear,
        StIssue,
        StWait,
        StFinish
    } frame_state_e;

    // History depth clamped into the usable range 1..NUM_SLOTS.
    function automatic logic [SLOT_WIDTH-1:0] eff_depth(
        input logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] hist
    );
        if (hist == '0) begin
            return SLOT_WIDTH'(1);
        end else if (hist > NUM_OF_HISTORY_FRAMES_WIDTH'(NUM_SLOTS)) begin
            return SLOT_WIDTH'(NUM_SLOTS);
        end else begin
            return SLOT_WIDTH'(hist);
        end
    endfunction

endpackage

// File: rtl/oflow_frame_slot_mod.sv
// Combinational history-slot selection: frame number modulo history depth (1..5).
module oflow_frame_slot_mod
    import oflow_MEM_buffer_define::*;
(
    input  logic [TOTAL_FRAME_NUM_WIDTH-1:0] frame_num_i,
    input  logic [SLOT_WIDTH-1:0]            depth_i,
    output logic [SLOT_WIDTH-1:0]            slot_o
);

    // Zero depth never reaches here from the clamp; it maps to slot 0 as a guard.
    always_comb begin
        slot_o = '0;
        if (depth_i != '0) begin
            slot_o = SLOT_WIDTH'(frame_num_i % TOTAL_FRAME_NUM_WIDTH'(depth_i));
        end
    end

endmodule

// File: rtl/oflow_fsm_buffer_frame_ctrl.sv
// Frame buffering controller: picks a history slot per frame, issues one write
// request per bbox pair, tracks per-slot end pointers and valid bitmap.
// Optional capacity check enabled by defining OFLOW_BUF_FRAME_CTRL_OVERFLOW_CHK_EN.
module oflow_fsm_buffer_frame_ctrl
    import oflow_MEM_buffer_define::*;
(
    input  logic                                   clk,
    input  logic                                   reset_N,
    input  logic                                   frame_start,
    input  logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num,
    input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames,
    input  logic [BBOX_NUM_WIDTH-1:0]              num_of_bbox,
    input  logic                                   done_write,
    output logic                                   start_write,
    output logic [SLOT_WIDTH-1:0]                  write_slot,
    output logic [NUM_SLOTS-1:0][ADDR_WIDTH-1:0]   end_pointers,
    output logic [NUM_SLOTS-1:0]                   valid_slots,
    output logic                                   busy,
    output logic                                   frame_done
`ifdef OFLOW_BUF_FRAME_CTRL_OVERFLOW_CHK_EN
    ,
    output logic                                   overflow
`endif
);

    frame_state_e                                 state_q;
    logic [TOTAL_FRAME_NUM_WIDTH-1:0]             frame_num_q;
    logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0]       hist_q;
    logic [BBOX_NUM_WIDTH-1:0]                    nbbox_q;
    logic [BBOX_NUM_WIDTH-1:0]                    remaining_q;
    logic [SLOT_WIDTH-1:0]                        write_slot_q;
    logic [NUM_SLOTS-1:0][ADDR_WIDTH-1:0]         end_ptr_q;
    logic [NUM_SLOTS-1:0]                         valid_q;
    logic                                         start_write_q;
    logic                                         frame_done_q;
    logic                                         busy_q;
`ifdef OFLOW_BUF_FRAME_CTRL_OVERFLOW_CHK_EN
    logic                                         overflow_q;
`endif

    logic [SLOT_WIDTH-1:0]     depth;
    logic [SLOT_WIDTH-1:0]     slot;
    logic [BBOX_NUM_WIDTH-1:0] step;
    logic [BBOX_NUM_WIDTH-1:0] rem_after;
    logic [BBOX_NUM_WIDTH-1:0] nbbox_eff;

    oflow_frame_slot_mod u_slot_mod (
        .frame_num_i (frame_num_q),
        .depth_i     (depth),
        .slot_o      (slot)
    );

    // Depth clamp, pair step (last pair of an odd count adds 1) and capacity truncation.
    always_comb begin
        depth     = eff_depth(hist_q);
        step      = (remaining_q > BBOX_NUM_WIDTH'(1)) ? BBOX_NUM_WIDTH'(2) : remaining_q;
        rem_after = remaining_q - step;
        nbbox_eff = nbbox_q;
`ifdef OFLOW_BUF_FRAME_CTRL_OVERFLOW_CHK_EN
        if (nbbox_q > BBOX_NUM_WIDTH'(MAX_BBOX_PER_SLOT)) begin
            nbbox_eff = BBOX_NUM_WIDTH'(MAX_BBOX_PER_SLOT);
        end
`endif
    end

    // Frame FSM with registered Moore outputs, pointers and valid bitmap.
    always_ff @(posedge clk) begin
        if (!reset_N) begin
            state_q       <= StIdle;
            frame_num_q   <= '0;
            hist_q        <= '0;
            nbbox_q       <= '0;
            remaining_q   <= '0;
            write_slot_q  <= '0;
            end_ptr_q     <= '0;
            valid_q       <= '0;
            start_write_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
`ifdef OFLOW_BUF_FRAME_CTRL_OVERFLOW_CHK_EN
            overflow_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    start_write_q <= 1'b0;
                    frame_done_q  <= 1'b0;
                    if (frame_start) begin
                        frame_num_q <= frame_num;
                        hist_q      <= num_of_history_frames;
                        nbbox_q     <= num_of_bbox;
                        busy_q      <= 1'b1;
                        state_q     <= StSetup;
`ifdef OFLOW_BUF_FRAME_CTRL_OVERFLOW_CHK_EN
                        overflow_q  <= 1'b0;
`endif
                    end
                end
                StSetup: begin
                    write_slot_q <= slot;
                    remaining_q  <= nbbox_eff;
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (SLOT_WIDTH'(i) >= depth) begin
                            valid_q[i] <= 1'b0;
                        end
                    end
`ifdef OFLOW_BUF_FRAME_CTRL_OVERFLOW_CHK_EN
                    overflow_q <= (nbbox_q > BBOX_NUM_WIDTH'(MAX_BBOX_PER_SLOT));
`endif
                    state_q <= StClear;
                end
                StClear: begin
                    end_ptr_q[write_slot_q] <= '0;
                    valid_q[write_slot_q]   <= 1'b0;
                    if (remaining_q == '0) begin
                        frame_done_q <= 1'b1;
                        state_q      <= StFinish;
                    end else begin
                        start_write_q <= 1'b1;
                        state_q       <= StIssue;
                    end
                end
                StIssue: begin
                    start_write_q <= 1'b0;
                    state_q       <= StWait;
                end
                StWait: begin
                    if (done_write) begin
                        end_ptr_q[write_slot_q] <= end_ptr_q[write_slot_q] + ADDR_WIDTH'(step);
                        remaining_q             <= rem_after;
                        if (rem_after != '0) begin
                            start_write_q <= 1'b1;
                            state_q       <= StIssue;
                        end else begin
                            frame_done_q <= 1'b1;
                            state_q      <= StFinish;
                        end
                    end
                end
                StFinish: begin
                    valid_q[write_slot_q] <= 1'b1;
                    frame_done_q          <= 1'b0;
                    busy_q                <= 1'b0;
                    state_q               <= StIdle;
                end
                default: begin
                    start_write_q <= 1'b0;
                    frame_done_q  <= 1'b0;
                    busy_q        <= 1'b0;
                    state_q       <= StIdle;
                end
            endcase
        end
    end

    assign start_write  = start_write_q;
    assign write_slot   = write_slot_q;
    assign end_pointers = end_ptr_q;
    assign valid_slots  = valid_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
`ifdef OFLOW_BUF_FRAME_CTRL_OVERFLOW_CHK_EN
    assign overflow     = overflow_q;
`endif

endmodule

// File: tb/tb_oflow_fsm_buffer_frame_ctrl.sv
// Directed bench for oflow_fsm_buffer_frame_ctrl with a frame-level reference model.
module tb_oflow_fsm_buffer_frame_ctrl;
    import oflow_MEM_buffer_define::*;

    logic                                   clk = 1'b0;
    logic                                   reset_N;
    logic                                   frame_start;
    logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num;
    logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames;
    logic [BBOX_NUM_WIDTH-1:0]              num_of_bbox;
    logic                                   done_write;
    logic                                   start_write;
    logic [SLOT_WIDTH-1:0]                  write_slot;
    logic [NUM_SLOTS-1:0][ADDR_WIDTH-1:0]   end_pointers;
    logic [NUM_SLOTS-1:0]                   valid_slots;
    logic                                   busy;
    logic                                   frame_done;
`ifdef OFLOW_BUF_FRAME_CTRL_OVERFLOW_CHK_EN
    logic                                   overflow;
`endif

    oflow_fsm_buffer_frame_ctrl dut (
        .clk                   (clk),
        .reset_N               (reset_N),
        .frame_start           (frame_start),
        .frame_num             (frame_num),
        .num_of_history_frames (num_of_history_frames),
        .num_of_bbox           (num_of_bbox),
        .done_write            (done_write),
        .start_write           (start_write),
        .write_slot            (write_slot),
        .end_pointers          (end_pointers),
        .valid_slots           (valid_slots),
        .busy                  (busy),
        .frame_done            (frame_done)
`ifdef OFLOW_BUF_FRAME_CTRL_OVERFLOW_CHK_EN
        ,
        .overflow              (overflow)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: stored bbox count per slot and complete-frame bitmap.
    logic [ADDR_WIDTH-1:0] ep_m [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  vm;
    int                    cur_slot = 0;
    bit                    mon_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clamp_depth(input int h);
        if (h < 1) return 1;
        if (h > 5) return 5;
        return h;
    endfunction

    function automatic int eff_bbox(input int n);
`ifdef OFLOW_BUF_FRAME_CTRL_OVERFLOW_CHK_EN
        if (n > 32) return 32;
`endif
        return n;
    endfunction

    // Continuous comparison against the model on every negedge.
    always @(negedge clk) begin
        if (mon_en && reset_N) begin
            if (!busy) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    chk("idle_end_ptr", 64'(end_pointers[i]), 64'(ep_m[i]));
                end
                chk("idle_valid", 64'(valid_slots), 64'(vm));
                chk("idle_start_write", 64'(start_write), 64'd0);
                chk("idle_frame_done", 64'(frame_done), 64'd0);
            end else begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (i != cur_slot) begin
                        chk("other_slot_ptr", 64'(end_pointers[i]), 64'(ep_m[i]));
                    end
                end
            end
        end
    end

    // Drive one frame, answer each start_write with done_write one cycle later.
    task automatic run_frame(input int fn, input int h, input int n, input bit stray,
                             input int exp_slot, input int exp_pulses);
        int pulses   = 0;
        int dones    = 0;
        int first_sw = -1;
        int first_fd = -1;
        int slot_seen = -1;
        bit prev_sw  = 1'b0;
        bit finished = 1'b0;
        int d        = clamp_depth(h);
        cur_slot              = fn % d;
        frame_num             = TOTAL_FRAME_NUM_WIDTH'(fn);
        num_of_history_frames = NUM_OF_HISTORY_FRAMES_WIDTH'(h);
        num_of_bbox           = BBOX_NUM_WIDTH'(n);
        frame_start           = 1'b1;
        for (int k = 1; k <= 300 && !finished; k++) begin
            @(negedge clk);
            frame_start = 1'b0;
            done_write  = 1'b0;
            if (prev_sw) done_write = 1'b1;
            prev_sw = start_write;
            if (start_write) begin
                pulses++;
                if (first_sw < 0) first_sw = k;
                if (stray) begin
                    // Early done_write (ISSUE) and a new frame_start while busy.
                    done_write  = 1'b1;
                    frame_start = 1'b1;
                    frame_num   = 8'd200;
                    num_of_bbox = 6'd1;
                end
            end
            if (frame_done) begin
                dones++;
                if (first_fd < 0) first_fd = k;
                slot_seen = int'(write_slot);
                for (int i = 0; i < NUM_SLOTS; i++) if (i >= d) vm[i] = 1'b0;
                ep_m[cur_slot] = ADDR_WIDTH'(eff_bbox(n));
                vm[cur_slot]   = 1'b1;
            end
            if (dones > 0 && !busy) finished = 1'b1;
        end
        frame_start = 1'b0;
        done_write  = 1'b0;
        chk("frame_completed_in_budget", 64'(finished), 64'd1);
        chk("start_write_pulses", 64'(pulses), 64'(exp_pulses));
        chk("frame_done_pulses", 64'(dones), 64'd1);
        chk("write_slot", 64'(slot_seen), 64'(exp_slot));
        if (n > 0) chk("start_write_latency", 64'(first_sw), 64'd3);
        else       chk("frame_done_latency", 64'(first_fd), 64'd3);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int  dw_issued;
        int  fd;
        int  sw_after;
        int  fd_after;
        bit  prev_sw;
        bit  aborted;

        reset_N = 1'b0; frame_start = 1'b0; done_write = 1'b0;
        frame_num = '0; num_of_history_frames = '0; num_of_bbox = '0;
        for (int i = 0; i < NUM_SLOTS; i++) ep_m[i] = '0;
        vm = '0;
        repeat (2) @(negedge clk);
        chk("rst_start_write", 64'(start_write), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_end_ptrs", 64'(end_pointers), 64'd0);
        chk("rst_valid", 64'(valid_slots), 64'd0);
        reset_N = 1'b1;
        mon_en  = 1'b1;
        @(negedge clk);

        // frame 12, depth 4, 9 bboxes -> slot 0, 5 pulses
        run_frame(12, 4, 9, 1'b0, 0, 5);
        chk("f1_end_ptr0", 64'(end_pointers[0]), 64'd9);
        chk("f1_valid", 64'(valid_slots), 64'b00001);
        // frame 13, depth 4, no bboxes -> slot 1, no pulses
        run_frame(13, 4, 0, 1'b0, 1, 0);
        chk("f2_end_ptr1", 64'(end_pointers[1]), 64'd0);
        chk("f2_valid", 64'(valid_slots), 64'b00011);
        // depth 0 clamps to 1 -> slot 0, bit 1 dropped
        run_frame(7, 0, 3, 1'b0, 0, 2);
        chk("f3_end_ptr0", 64'(end_pointers[0]), 64'd3);
        chk("f3_valid", 64'(valid_slots), 64'b00001);
        // depth 7 clamps to 5 -> 12 % 5 = 2
        run_frame(12, 7, 4, 1'b0, 2, 2);
        chk("f4_end_ptr2", 64'(end_pointers[2]), 64'd4);
        chk("f4_valid", 64'(valid_slots), 64'b00101);

        // stray done_write while idle
        done_write = 1'b1;
        repeat (2) @(negedge clk);
        done_write = 1'b0;
        @(negedge clk);
        chk("stray_idle_end_ptr0", 64'(end_pointers[0]), 64'd3);

        // stray frame_start / early done_write during the frame
        run_frame(9, 5, 6, 1'b1, 4, 3);
        chk("f5_end_ptr4", 64'(end_pointers[4]), 64'd6);
        chk("f5_valid", 64'(valid_slots), 64'b10101);

        // 40 bboxes, depth 3 -> slot 1
`ifdef OFLOW_BUF_FRAME_CTRL_OVERFLOW_CHK_EN
        run_frame(1, 3, 40, 1'b0, 1, 16);
        chk("f6_end_ptr1", 64'(end_pointers[1]), 64'd32);
        chk("f6_overflow", 64'(overflow), 64'd1);
`else
        run_frame(1, 3, 40, 1'b0, 1, 20);
        chk("f6_end_ptr1", 64'(end_pointers[1]), 64'd40);
`endif
        chk("f6_valid", 64'(valid_slots), 64'b00111);

        // reset after the second done_write of a 9-bbox frame
        cur_slot = 3;
        frame_num = 8'd3; num_of_history_frames = 3'd5; num_of_bbox = 6'd9;
        frame_start = 1'b1;
        dw_issued = 0; fd = 0; prev_sw = 1'b0; aborted = 1'b0;
        for (int k = 0; k < 100 && !aborted; k++) begin
            @(negedge clk);
            frame_start = 1'b0;
            done_write  = 1'b0;
            if (dw_issued == 2) begin
                reset_N = 1'b0;
                for (int i = 0; i < NUM_SLOTS; i++) ep_m[i] = '0;
                vm = '0;
                aborted = 1'b1;
            end else begin
                if (prev_sw) begin
                    done_write = 1'b1;
                    dw_issued++;
                end
                prev_sw = start_write;
                if (frame_done) fd++;
            end
        end
        chk("abort_reached", 64'(aborted), 64'd1);
        chk("abort_no_frame_done_before", 64'(fd), 64'd0);
        @(negedge clk);
        chk("abort_start_write", 64'(start_write), 64'd0);
        chk("abort_frame_done", 64'(frame_done), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_write_slot", 64'(write_slot), 64'd0);
        chk("abort_end_ptrs", 64'(end_pointers), 64'd0);
        chk("abort_valid", 64'(valid_slots), 64'd0);
`ifdef OFLOW_BUF_FRAME_CTRL_OVERFLOW_CHK_EN
        chk("abort_overflow", 64'(overflow), 64'd0);
`endif
        reset_N = 1'b1;
        sw_after = 0; fd_after = 0;
        repeat (6) begin
            @(negedge clk);
            if (start_write) sw_after++;
            if (frame_done) fd_after++;
        end
        chk("post_abort_start_write", 64'(sw_after), 64'd0);
        chk("post_abort_frame_done", 64'(fd_after), 64'd0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
